// File: rtl/alu_system_if.sv
// Control bundle of the alu_system datapath. A future control unit drives
// every select/enable pin from the master side. The datapath hands back the
// instruction register and the flag nibble, which that unit will decode.
interface alu_system_if;
    logic [2:0]  RF_O1Sel;
    logic [2:0]  RF_O2Sel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RSel;
    logic [3:0]  RF_TSel;
    logic [3:0]  ALU_FunSel;
    logic [1:0]  ARF_OutASel;
    logic [1:0]  ARF_OutBSel;
    logic [1:0]  ARF_FunSel;
    logic [3:0]  ARF_RSel;
    logic        IR_LH;
    logic        IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR;
    logic        Mem_CS;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic        MuxCSel;
    logic [15:0] IR_Out;
    logic [3:0]  ALU_FlagOut;

    modport master (
        output RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
               ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel,
        input  IR_Out, ALU_FlagOut
    );

    modport slave (
        input  RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
               ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel,
        output IR_Out, ALU_FlagOut
    );
endinterface

// File: rtl/alu_system.sv
// CPU datapath: register file (T1..T4, R1..R4), 8-bit ALU with registered
// {Z,C,N,O} flags, address register file (AR, SP, PCpast, PC), 16-bit IR,
// 256x8 RAM and the three source multiplexers. All control is external.
module alu_system (
    input  logic         Clock,
    input  logic         Reset,
    alu_system_if.slave  ctl
);

    // Nets kept under these names so they can be probed hierarchically.
    logic [7:0]  RF_O1;
    logic [7:0]  RF_O2;
    logic [7:0]  ALU_Out;
    logic [7:0]  ARF_OutA;
    logic [7:0]  ARF_OutB;
    logic [7:0]  MemOut;
    logic [7:0]  MuxAOut;
    logic [7:0]  MuxBOut;
    logic [7:0]  MuxCOut;
    logic [3:0]  ALU_FlagOut;
    logic [15:0] IR_Out;

    // Storage. RF index equals the read-select code (0..3 T1..T4, 4..7 R1..R4);
    // ARF index equals the out-select code (0 AR, 1 SP, 2 PCpast, 3 PC).
    logic [7:0]  rf_r  [0:7];
    logic [7:0]  arf_r [0:3];
    logic [7:0]  mem_r [0:255];
    logic [15:0] ir_r;
    logic [3:0]  flag_r;

    logic [7:0]  rf_en_s;
    logic [3:0]  arf_en_s;
    logic [7:0]  alu_a_s;
    logic [7:0]  alu_b_s;
    logic [8:0]  alu_sum_s;
    logic        alu_c_s;
    logic        alu_o_s;

    // Shared clear/load/decrement/increment rule of RF and ARF (8-bit wrap).
    function automatic logic [7:0] fun_apply(input logic [1:0] fs,
                                             input logic [7:0] cur,
                                             input logic [7:0] ld);
        logic [7:0] nxt;
        case (fs)
            2'b00:   nxt = 8'h00;
            2'b01:   nxt = ld;
            2'b10:   nxt = cur - 8'h01;
            2'b11:   nxt = cur + 8'h01;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // Enable bits are MSB-first on the pins; flip them into storage index order.
    assign rf_en_s  = {ctl.RF_RSel[0], ctl.RF_RSel[1], ctl.RF_RSel[2], ctl.RF_RSel[3],
                       ctl.RF_TSel[0], ctl.RF_TSel[1], ctl.RF_TSel[2], ctl.RF_TSel[3]};
    assign arf_en_s = {ctl.ARF_RSel[0], ctl.ARF_RSel[1], ctl.ARF_RSel[2], ctl.ARF_RSel[3]};

    assign ALU_FlagOut     = flag_r;
    assign IR_Out          = ir_r;
    assign ctl.ALU_FlagOut = flag_r;
    assign ctl.IR_Out      = ir_r;
    assign alu_a_s         = MuxCOut;
    assign alu_b_s         = RF_O2;

    // Combinational register-file and address-register read ports.
    always_comb begin
        RF_O1    = rf_r[ctl.RF_O1Sel];
        RF_O2    = rf_r[ctl.RF_O2Sel];
        ARF_OutA = arf_r[ctl.ARF_OutASel];
        ARF_OutB = arf_r[ctl.ARF_OutBSel];
    end

    // Source multiplexers feeding the RF load, ARF load and ALU A input.
    always_comb begin
        case (ctl.MuxASel)
            2'b00:   MuxAOut = ALU_Out;
            2'b01:   MuxAOut = MemOut;
            2'b10:   MuxAOut = ir_r[7:0];
            2'b11:   MuxAOut = ARF_OutA;
            default: MuxAOut = 8'h00;
        endcase
        case (ctl.MuxBSel)
            2'b00:   MuxBOut = ALU_Out;
            2'b01:   MuxBOut = MemOut;
            2'b10:   MuxBOut = ir_r[7:0];
            2'b11:   MuxBOut = ARF_OutA;
            default: MuxBOut = 8'h00;
        endcase
        if (ctl.MuxCSel) begin
            MuxCOut = ARF_OutA;
        end else begin
            MuxCOut = RF_O1;
        end
    end

    // ALU result plus next C/O; ops that do not touch C or O keep the stored bit.
    always_comb begin
        alu_sum_s = 9'h000;
        ALU_Out   = 8'h00;
        alu_c_s   = flag_r[2];
        alu_o_s   = flag_r[0];
        case (ctl.ALU_FunSel)
            4'b0000: ALU_Out = alu_a_s;
            4'b0001: ALU_Out = alu_b_s;
            4'b0010: ALU_Out = ~alu_a_s;
            4'b0011: ALU_Out = ~alu_b_s;
            4'b0100, 4'b0101: begin
                alu_sum_s = {1'b0, alu_a_s} + {1'b0, alu_b_s}
                          + {8'h00, (ctl.ALU_FunSel[0] & flag_r[2])};
                ALU_Out   = alu_sum_s[7:0];
                alu_c_s   = alu_sum_s[8];
                alu_o_s   = (alu_a_s[7] == alu_b_s[7]) && (alu_sum_s[7] != alu_a_s[7]);
            end
            4'b0110: begin
                // Two's-complement subtract: carry set means no borrow.
                alu_sum_s = {1'b0, alu_a_s} + {1'b0, ~alu_b_s} + 9'h001;
                ALU_Out   = alu_sum_s[7:0];
                alu_c_s   = alu_sum_s[8];
                alu_o_s   = (alu_a_s[7] != alu_b_s[7]) && (alu_sum_s[7] != alu_a_s[7]);
            end
            4'b0111: ALU_Out = alu_a_s & alu_b_s;
            4'b1000: ALU_Out = alu_a_s | alu_b_s;
            4'b1001: ALU_Out = alu_a_s ^ alu_b_s;
            4'b1010: begin
                ALU_Out = {alu_a_s[6:0], 1'b0};
                alu_c_s = alu_a_s[7];
            end
            4'b1011: begin
                ALU_Out = {1'b0, alu_a_s[7:1]};
                alu_c_s = alu_a_s[0];
            end
            4'b1100: begin
                ALU_Out = {alu_a_s[6:0], 1'b0};
                alu_c_s = alu_a_s[7];
                alu_o_s = alu_a_s[7] ^ alu_a_s[6];
            end
            4'b1101: begin
                ALU_Out = {alu_a_s[7], alu_a_s[7:1]};
                alu_c_s = alu_a_s[0];
            end
            4'b1110: begin
                ALU_Out = {alu_a_s[6:0], alu_a_s[7]};
                alu_c_s = alu_a_s[7];
            end
            4'b1111: begin
                ALU_Out = {alu_a_s[0], alu_a_s[7:1]};
                alu_c_s = alu_a_s[0];
            end
            default: ALU_Out = 8'h00;
        endcase
    end

    // Flag nibble {Z,C,N,O} is captured from the ALU on every edge.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            flag_r <= 4'h0;
        end else begin
            flag_r <= {(ALU_Out == 8'h00), alu_c_s, ALU_Out[7], alu_o_s};
        end
    end

    // Register file: each enabled register applies RF_FunSel, loading from MuxA.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < 8; i++) begin
                rf_r[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (rf_en_s[i]) begin
                    rf_r[i] <= fun_apply(ctl.RF_FunSel, rf_r[i], MuxAOut);
                end
            end
        end
    end

    // Address registers: same update rule, loading from MuxB.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < 4; i++) begin
                arf_r[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (arf_en_s[i]) begin
                    arf_r[i] <= fun_apply(ctl.ARF_FunSel, arf_r[i], MuxBOut);
                end
            end
        end
    end

    // Instruction register: half-word loads from memory, full 16-bit inc/dec.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ir_r <= 16'h0000;
        end else if (ctl.IR_Enable) begin
            case (ctl.IR_Funsel)
                2'b00:   ir_r <= 16'h0000;
                2'b01: begin
                    if (ctl.IR_LH) begin
                        ir_r[15:8] <= MemOut;
                    end else begin
                        ir_r[7:0] <= MemOut;
                    end
                end
                2'b10:   ir_r <= ir_r - 16'h0001;
                2'b11:   ir_r <= ir_r + 16'h0001;
                default: ir_r <= ir_r;
            endcase
        end
    end

    // RAM write port; contents deliberately survive Reset.
    always_ff @(posedge Clock) begin
        if (!ctl.Mem_CS && ctl.Mem_WR) begin
            mem_r[ARF_OutB] <= ALU_Out;
        end
    end

    // Asynchronous RAM read; the bus idles at zero when not reading.
    always_comb begin
        if (!ctl.Mem_CS && !ctl.Mem_WR) begin
            MemOut = mem_r[ARF_OutB];
        end else begin
            MemOut = 8'h00;
        end
    end

endmodule

// File: tb/tb_alu_system.sv
// Self-checking bench for alu_system: directed scenarios followed by random
// control words, all compared against a behavioural model of the datapath.
module tb_alu_system;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    always #5 Clock = ~Clock;

    alu_system_if ctl_if ();

    alu_system dut (
        .Clock (Clock),
        .Reset (Reset),
        .ctl   (ctl_if)
    );

    typedef struct packed {
        logic [2:0] o1;
        logic [2:0] o2;
        logic [1:0] rf_fun;
        logic [3:0] rsel;
        logic [3:0] tsel;
        logic [3:0] alu_fun;
        logic [1:0] oa;
        logic [1:0] ob;
        logic [1:0] arf_fun;
        logic [3:0] arsel;
        logic       lh;
        logic       ir_en;
        logic [1:0] ir_fun;
        logic       wr;
        logic       cs;
        logic [1:0] ma;
        logic [1:0] mb;
        logic       mc;
    } ctl_t;

    int   total_cnt = 0;
    int   bad_cnt   = 0;
    int   m_rf  [8];
    int   m_arf [4];
    int   m_mem [256];
    int   m_ir;
    bit   m_z, m_c, m_n, m_o;
    ctl_t cur;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic ctl_t nop_ctl();
        ctl_t c;
        c    = '0;
        c.cs = 1'b1;
        return c;
    endfunction

    // clear / load / decrement / increment with wrap at 'modulus'
    function automatic int fun_ref(input int fs, input int v, input int ld, input int modulus);
        case (fs)
            0:       return 0;
            1:       return ld;
            2:       return (v + modulus - 1) % modulus;
            default: return (v + 1) % modulus;
        endcase
    endfunction

    function automatic int sgn(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // ALU reference in plain integer arithmetic
    task automatic alu_ref(input int f, input int a, input int b, input bit cin,
                           output int res, output bit cu, output bit cv,
                           output bit ou, output bit ov);
        int t;
        int s;
        cu = 1'b0; cv = 1'b0; ou = 1'b0; ov = 1'b0; res = 0;
        case (f)
            0:  res = a;
            1:  res = b;
            2:  res = 255 - a;
            3:  res = 255 - b;
            4, 5: begin
                t   = a + b + ((f == 5) ? int'(cin) : 0);
                s   = sgn(a) + sgn(b) + ((f == 5) ? int'(cin) : 0);
                res = t % 256; cu = 1'b1; cv = (t > 255);
                ou  = 1'b1;    ov = (s > 127) || (s < -128);
            end
            6: begin
                s   = sgn(a) - sgn(b);
                res = (a - b + 256) % 256; cu = 1'b1; cv = (a >= b);
                ou  = 1'b1; ov = (s > 127) || (s < -128);
            end
            7:  res = a & b;
            8:  res = a | b;
            9:  res = a ^ b;
            10: begin res = (a * 2) % 256; cu = 1'b1; cv = (a >= 128); end
            11: begin res = a / 2; cu = 1'b1; cv = (a % 2 == 1); end
            12: begin
                res = (a * 2) % 256; cu = 1'b1; cv = (a >= 128);
                s   = sgn(a) * 2; ou = 1'b1; ov = (s > 127) || (s < -128);
            end
            13: begin res = (sgn(a) >>> 1) & 255; cu = 1'b1; cv = (a % 2 == 1); end
            14: begin res = (a * 2) % 256 + a / 128; cu = 1'b1; cv = (a >= 128); end
            default: begin res = a / 2 + (a % 2) * 128; cu = 1'b1; cv = (a % 2 == 1); end
        endcase
    endtask

    task automatic drive(input ctl_t c, input logic rst);
        @(negedge Clock);
        Reset              = rst;
        ctl_if.RF_O1Sel    = c.o1;
        ctl_if.RF_O2Sel    = c.o2;
        ctl_if.RF_FunSel   = c.rf_fun;
        ctl_if.RF_RSel     = c.rsel;
        ctl_if.RF_TSel     = c.tsel;
        ctl_if.ALU_FunSel  = c.alu_fun;
        ctl_if.ARF_OutASel = c.oa;
        ctl_if.ARF_OutBSel = c.ob;
        ctl_if.ARF_FunSel  = c.arf_fun;
        ctl_if.ARF_RSel    = c.arsel;
        ctl_if.IR_LH       = c.lh;
        ctl_if.IR_Enable   = c.ir_en;
        ctl_if.IR_Funsel   = c.ir_fun;
        ctl_if.Mem_WR      = c.wr;
        ctl_if.Mem_CS      = c.cs;
        ctl_if.MuxASel     = c.ma;
        ctl_if.MuxBSel     = c.mb;
        ctl_if.MuxCSel     = c.mc;
        cur                = c;
        #1;
    endtask

    // compare every observable against the model, then advance the model one edge
    task automatic settle();
        int o1, o2, oa, ob, mo, mc, ma, mb, res;
        bit cu, cv, ou, ov, writing;
        o1 = m_rf[cur.o1];
        o2 = m_rf[cur.o2];
        oa = m_arf[cur.oa];
        ob = m_arf[cur.ob];
        writing = (cur.cs == 1'b0) && (cur.wr == 1'b1);
        mo = ((cur.cs == 1'b0) && (cur.wr == 1'b0)) ? m_mem[ob] : 0;
        mc = cur.mc ? oa : o1;
        alu_ref(int'(cur.alu_fun), mc, o2, m_c, res, cu, cv, ou, ov);
        case (cur.ma)
            2'd0: ma = res;  2'd1: ma = mo;  2'd2: ma = m_ir % 256;  default: ma = oa;
        endcase
        case (cur.mb)
            2'd0: mb = res;  2'd1: mb = mo;  2'd2: mb = m_ir % 256;  default: mb = oa;
        endcase

        check_eq("RF_O1",    {8'h00, dut.RF_O1},    16'(o1));
        check_eq("RF_O2",    {8'h00, dut.RF_O2},    16'(o2));
        check_eq("ARF_OutA", {8'h00, dut.ARF_OutA}, 16'(oa));
        check_eq("ARF_OutB", {8'h00, dut.ARF_OutB}, 16'(ob));
        check_eq("MuxCOut",  {8'h00, dut.MuxCOut},  16'(mc));
        check_eq("ALU_Out",  {8'h00, dut.ALU_Out},  16'(res));
        check_eq("MuxAOut",  {8'h00, dut.MuxAOut},  16'(ma));
        check_eq("MuxBOut",  {8'h00, dut.MuxBOut},  16'(mb));
        check_eq("IR_Out",   dut.IR_Out,            16'(m_ir));
        check_eq("FlagOut",  {12'h000, dut.ALU_FlagOut}, {12'h000, m_z, m_c, m_n, m_o});
        if (!writing) begin
            check_eq("MemOut", {8'h00, dut.MemOut}, 16'(mo));
        end

        if (writing) begin
            m_mem[ob] = res;
        end
        if (Reset == 1'b0) begin
            for (int i = 0; i < 8; i++) m_rf[i] = 0;
            for (int i = 0; i < 4; i++) m_arf[i] = 0;
            m_ir = 0;
            m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_o = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cur.tsel[3 - i]) m_rf[i]     = fun_ref(int'(cur.rf_fun), m_rf[i], ma, 256);
                if (cur.rsel[3 - i]) m_rf[i + 4] = fun_ref(int'(cur.rf_fun), m_rf[i + 4], ma, 256);
                if (cur.arsel[3 - i]) m_arf[i]   = fun_ref(int'(cur.arf_fun), m_arf[i], mb, 256);
            end
            if (cur.ir_en) begin
                if (cur.ir_fun == 2'b01) begin
                    m_ir = cur.lh ? (mo * 256 + m_ir % 256) : ((m_ir / 256) * 256 + mo);
                end else begin
                    m_ir = fun_ref(int'(cur.ir_fun), m_ir, 0, 65536);
                end
            end
            m_z = (res == 0);
            m_n = (res >= 128);
            if (cu) m_c = cv;
            if (ou) m_o = ov;
        end
    endtask

    task automatic run(input ctl_t c);
        drive(c, 1'b1);
        settle();
    endtask

    initial begin
        ctl_t        c;
        logic [63:0] r;
        logic        rst;

        for (int i = 0; i < 8; i++) m_rf[i] = 0;
        for (int i = 0; i < 4; i++) m_arf[i] = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = 0;
        m_ir = 0;
        m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_o = 1'b0;

        // reset state
        drive(nop_ctl(), 1'b0);
        check_eq("rst_RF_O1",    {8'h00, dut.RF_O1},    16'h0000);
        check_eq("rst_RF_O2",    {8'h00, dut.RF_O2},    16'h0000);
        check_eq("rst_ARF_OutA", {8'h00, dut.ARF_OutA}, 16'h0000);
        check_eq("rst_ARF_OutB", {8'h00, dut.ARF_OutB}, 16'h0000);
        check_eq("rst_IR_Out",   dut.IR_Out,            16'h0000);
        check_eq("rst_FlagOut",  {12'h000, dut.ALU_FlagOut}, 16'h0000);
        settle();

        // zero the whole RAM: write T1 (=0) while AR steps, using pre-edge address
        c = nop_ctl(); c.cs = 1'b0; c.wr = 1'b1; c.arsel = 4'b1000; c.arf_fun = 2'b11;
        repeat (256) run(c);

        // T1 = 00-1 = FF, then mem[0] = LSR(FF) = 7F
        c = nop_ctl(); c.tsel = 4'b1000; c.rf_fun = 2'b10; run(c);
        c = nop_ctl(); c.alu_fun = 4'b1011; c.cs = 1'b0; c.wr = 1'b1;
        drive(c, 1'b1);
        check_eq("lsr_ff", {8'h00, dut.ALU_Out}, 16'h007F);
        settle();
        // IR low = 7F, R1 = IR low
        c = nop_ctl(); c.cs = 1'b0; c.ir_en = 1'b1; c.ir_fun = 2'b01; run(c);
        c = nop_ctl(); c.ma = 2'b10; c.rsel = 4'b1000; c.rf_fun = 2'b01; run(c);
        // IR = 0 then 1; R2 = IR low
        c = nop_ctl(); c.ir_en = 1'b1; c.ir_fun = 2'b00; run(c);
        c.ir_fun = 2'b11; run(c);
        c = nop_ctl(); c.ma = 2'b10; c.rsel = 4'b0100; c.rf_fun = 2'b01; run(c);

        // 7F + 01 -> 80, Z=0 C=0 N=1 O=1
        c = nop_ctl(); c.alu_fun = 4'b0100; c.o1 = 3'b100; c.o2 = 3'b101;
        drive(c, 1'b1);
        check_eq("add_res", {8'h00, dut.ALU_Out}, 16'h0080);
        settle();
        drive(nop_ctl(), 1'b1);
        check_eq("add_flags", {12'h000, dut.ALU_FlagOut}, 16'h0003);
        settle();

        // R3 = 5, then 5 - 5 -> 00, Z=1 C=1 N=0
        c = nop_ctl(); c.rsel = 4'b0010; c.rf_fun = 2'b11;
        repeat (5) run(c);
        c = nop_ctl(); c.alu_fun = 4'b0110; c.o1 = 3'b110; c.o2 = 3'b110;
        drive(c, 1'b1);
        check_eq("sub_res", {8'h00, dut.ALU_Out}, 16'h0000);
        settle();
        drive(nop_ctl(), 1'b1);
        check_eq("sub_zcn", {13'h0000, dut.ALU_FlagOut[3:1]}, 16'h0006);
        settle();

        // AR clear, decrement wraps to FF, increment wraps to 00
        c = nop_ctl(); c.arsel = 4'b1000; c.arf_fun = 2'b00; run(c);
        c.arf_fun = 2'b10; run(c);
        drive(nop_ctl(), 1'b1);
        check_eq("ar_dec_wrap", {8'h00, dut.ARF_OutA}, 16'h00FF);
        settle();
        c.arf_fun = 2'b11; run(c);
        drive(nop_ctl(), 1'b1);
        check_eq("ar_inc_wrap", {8'h00, dut.ARF_OutA}, 16'h0000);
        settle();

        // AR = 10, T3 = 3C, write mem[10] = 3C, read it back, load IR high
        repeat (16) run(c);
        c = nop_ctl(); c.tsel = 4'b0010; c.rf_fun = 2'b11;
        repeat (60) run(c);
        c = nop_ctl(); c.o1 = 3'b010; c.cs = 1'b0; c.wr = 1'b1;
        drive(c, 1'b1);
        check_eq("wr_data", {8'h00, dut.ALU_Out}, 16'h003C);
        check_eq("wr_addr", {8'h00, dut.ARF_OutB}, 16'h0010);
        settle();
        c = nop_ctl(); c.cs = 1'b0;
        drive(c, 1'b1);
        check_eq("mem_read", {8'h00, dut.MemOut}, 16'h003C);
        settle();
        c = nop_ctl(); c.ir_en = 1'b1; c.ir_fun = 2'b00; run(c);
        c = nop_ctl(); c.cs = 1'b0; c.ir_en = 1'b1; c.ir_fun = 2'b01; c.lh = 1'b1; run(c);
        drive(nop_ctl(), 1'b1);
        check_eq("ir_high_load", dut.IR_Out, 16'h3C00);
        settle();

        // R1 = 81; rotate left -> 03 with C=1; arithmetic right -> C0
        c = nop_ctl(); c.rsel = 4'b1000; c.rf_fun = 2'b11;
        repeat (2) run(c);
        c = nop_ctl(); c.alu_fun = 4'b1110; c.o1 = 3'b100;
        drive(c, 1'b1);
        check_eq("csl_res", {8'h00, dut.ALU_Out}, 16'h0003);
        settle();
        drive(nop_ctl(), 1'b1);
        check_eq("csl_carry", {15'h0000, dut.ALU_FlagOut[2]}, 16'h0001);
        settle();
        c = nop_ctl(); c.alu_fun = 4'b1101; c.o1 = 3'b100;
        drive(c, 1'b1);
        check_eq("asr_res", {8'h00, dut.ALU_Out}, 16'h00C0);
        settle();

        // random control words, with an occasional reset (RAM must survive it)
        for (int n = 0; n < 2000; n++) begin
            r = {$urandom(), $urandom()};
            c = r[$bits(ctl_t)-1:0];
            if (!c.cs && c.wr) begin
                if (c.ma == 2'b01) c.ma = 2'b00;
                if (c.mb == 2'b01) c.mb = 2'b00;
                if (c.ir_fun == 2'b01) c.ir_fun = 2'b11;
            end
            rst = ($urandom_range(0, 63) != 0);
            drive(c, rst);
            settle();
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
